// File: rtl/tron_pkg.sv
// Shared playfield definitions: colour codes, screen geometry and the tally FSM states.
package tron_pkg;

  localparam logic [2:0] BG_COL    = 3'b000;
  localparam logic [2:0] P1_COL    = 3'b001;
  localparam logic [2:0] P2_COL    = 3'b010;
  localparam logic [2:0] P3_COL    = 3'b100;
  localparam logic [2:0] P4_COL    = 3'b110;
  localparam logic [2:0] TIMER_COL = 3'b111;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int ADDR_W   = 15;
  localparam int COUNT_W  = 15;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DRAIN,
    DECIDE,
    DONE
  } state_e;

endpackage

// File: rtl/territory_tally_winner_select.sv
// Combinational 4-way argmax; strict compare so ties go to the lowest player index.
module winner_select
  import tron_pkg::*;
(
  input  logic [COUNT_W-1:0] p1_i,
  input  logic [COUNT_W-1:0] p2_i,
  input  logic [COUNT_W-1:0] p3_i,
  input  logic [COUNT_W-1:0] p4_i,
  output logic [1:0]         winner_o
);

  logic [COUNT_W-1:0] best;

  always_comb begin
    best     = p1_i;
    winner_o = 2'd0;
    if (p2_i > best) begin
      best     = p2_i;
      winner_o = 2'd1;
    end
    if (p3_i > best) begin
      best     = p3_i;
      winner_o = 2'd2;
    end
    if (p4_i > best) begin
      best     = p4_i;
      winner_o = 2'd3;
    end
  end

endmodule

// File: rtl/territory_tally.sv
// Post-round playfield reader: sweeps every cell once, counts each player's
// territory and latches the counts plus the winning player.
module territory_tally
  import tron_pkg::*;
#(
  parameter int WIDTH       = SCREEN_W,
  parameter int HEIGHT      = SCREEN_H,
  parameter int X_BITS      = 8,
  parameter int Y_BITS      = 7,
  parameter int RAM_LATENCY = 1
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     start,
  input  logic [2:0]               q,
  output logic [X_BITS+Y_BITS-1:0] address,
  output logic                     busy,
  output logic                     done,
  output logic                     valid,
  output logic [COUNT_W-1:0]       p1_count,
  output logic [COUNT_W-1:0]       p2_count,
  output logic [COUNT_W-1:0]       p3_count,
  output logic [COUNT_W-1:0]       p4_count,
  output logic [1:0]               winner
);

  localparam logic [X_BITS-1:0] X_LAST     = X_BITS'(WIDTH - 1);
  localparam logic [Y_BITS-1:0] Y_LAST     = Y_BITS'(HEIGHT - 1);
  localparam logic [1:0]        DRAIN_INIT = 2'(RAM_LATENCY - 1);

  state_e                      state_q;
  logic [X_BITS-1:0]           x_q;
  logic [Y_BITS-1:0]           y_q;
  logic [1:0]                  drain_q;
  logic                        busy_q, done_q, valid_q;
  logic [1:0]                  winner_q, win_sel;
  logic [RAM_LATENCY-1:0]      tag_q, tag_d;
  logic [3:0][COUNT_W-1:0]     cnt_q, cnt_d;
  logic                        accept;

  // A start landing in the done cycle is dropped so one request gives one tally.
  assign accept = (state_q == IDLE) && start && !done_q;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      drain_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      winner_q <= 2'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          state_q <= SCAN;
          x_q     <= '0;
          y_q     <= '0;
          busy_q  <= 1'b1;
          valid_q <= 1'b0;
        end
        SCAN: begin
          if (y_q == Y_LAST) begin
            if (x_q == X_LAST) begin
              state_q <= DRAIN;
              drain_q <= DRAIN_INIT;
            end else begin
              x_q <= x_q + 1'b1;
              y_q <= '0;
            end
          end else begin
            y_q <= y_q + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_q == 2'd0) state_q <= DECIDE;
          else                 drain_q <= drain_q - 1'b1;
        end
        DECIDE: begin
          winner_q <= win_sel;
          state_q  <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag bit k marks that the address issued k+1 cycles ago was a real sweep read.
  always_comb begin
    tag_d    = tag_q << 1;
    tag_d[0] = (state_q == SCAN);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if (tag_q[RAM_LATENCY-1]) begin
      case (q)
        P1_COL:  cnt_d[0] = cnt_q[0] + COUNT_W'(1);
        P2_COL:  cnt_d[1] = cnt_q[1] + COUNT_W'(1);
        P3_COL:  cnt_d[2] = cnt_q[2] + COUNT_W'(1);
        P4_COL:  cnt_d[3] = cnt_q[3] + COUNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      tag_q <= '0;
      cnt_q <= '0;
    end else begin
      tag_q <= tag_d;
      cnt_q <= cnt_d;
    end
  end

  winner_select u_winner (
    .p1_i    (cnt_q[0]),
    .p2_i    (cnt_q[1]),
    .p3_i    (cnt_q[2]),
    .p4_i    (cnt_q[3]),
    .winner_o(win_sel)
  );

  assign address  = {x_q, y_q};
  assign busy     = busy_q;
  assign done     = done_q;
  assign valid    = valid_q;
  assign p1_count = cnt_q[0];
  assign p2_count = cnt_q[1];
  assign p3_count = cnt_q[2];
  assign p4_count = cnt_q[3];
  assign winner   = winner_q;

endmodule

// File: tb/tb_territory_tally.sv
// Bench for territory_tally: a 160x120 latency-1 instance and a 3x2 latency-3
// instance, each fed by a RAM model, checked against a cell-counting model.
module tb_territory_tally;

  logic        clk = 1'b0;
  logic        rst;
  logic        start [2];
  logic [2:0]  q     [2];
  logic [14:0] addr  [2];
  logic        busy  [2];
  logic        done  [2];
  logic        valid [2];
  logic [14:0] c1 [2], c2 [2], c3 [2], c4 [2];
  logic [1:0]  win   [2];

  territory_tally u_big (
    .CLOCK_50(clk), .reset(rst), .start(start[0]), .q(q[0]), .address(addr[0]),
    .busy(busy[0]), .done(done[0]), .valid(valid[0]),
    .p1_count(c1[0]), .p2_count(c2[0]), .p3_count(c3[0]), .p4_count(c4[0]),
    .winner(win[0])
  );

  territory_tally #(.WIDTH(3), .HEIGHT(2), .RAM_LATENCY(3)) u_small (
    .CLOCK_50(clk), .reset(rst), .start(start[1]), .q(q[1]), .address(addr[1]),
    .busy(busy[1]), .done(done[1]), .valid(valid[1]),
    .p1_count(c1[1]), .p2_count(c2[1]), .p3_count(c3[1]), .p4_count(c4[1]),
    .winner(win[1])
  );

  always #5 clk = ~clk;

  function automatic int wd(int i);  return (i == 0) ? 160 : 3; endfunction
  function automatic int ht(int i);  return (i == 0) ? 120 : 2; endfunction
  function automatic int lat(int i); return (i == 0) ? 1 : 3;   endfunction
  function automatic int ncell(int i); return wd(i) * ht(i); endfunction
  function automatic int ca(int x, int y); return (x << 7) | y; endfunction

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input int i, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s[%0d]: got %0d expected %0d at %0t", nm, i, act, exp, $time);
    end
  endtask

  // RAM model: q returns the cell addressed lat cycles ago; anything not read
  // during a sweep comes back as a player colour so stray counting shows up.
  logic [2:0]  mem [2][32768];
  logic [14:0] pa  [2][3];
  logic        pb  [2][3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 3; j++) pb[i][j] <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        pa[i][0] <= addr[i];
        pb[i][0] <= busy[i];
        for (int j = 1; j < 3; j++) begin
          pa[i][j] <= pa[i][j-1];
          pb[i][j] <= pb[i][j-1];
        end
      end
    end
  end

  assign q[0] = pb[0][0] ? mem[0][pa[0][0]] : 3'b001;
  assign q[1] = pb[1][2] ? mem[1][pa[1][2]] : 3'b001;

  // Expected tally of the current RAM contents, loaded by the stimulus.
  int ecl [2][4];
  int ewl [2];

  task automatic tally(input int i);
    for (int p = 0; p < 4; p++) ecl[i][p] = 0;
    for (int x = 0; x < wd(i); x++)
      for (int y = 0; y < ht(i); y++)
        case (mem[i][15'(ca(x, y))])
          3'b001: ecl[i][0]++;
          3'b010: ecl[i][1]++;
          3'b100: ecl[i][2]++;
          3'b110: ecl[i][3]++;
          default: ;
        endcase
    ewl[i] = 0;
    for (int p = 1; p < 4; p++) if (ecl[i][p] > ecl[i][ewl[i]]) ewl[i] = p;
  endtask

  // Transaction-level timing model: a tally is a fixed-length run of edges.
  bit run [2]    = '{1'b0, 1'b0};
  int e   [2]    = '{0, 0};
  bit mdone [2]  = '{1'b0, 1'b0};
  bit mvalid [2] = '{1'b0, 1'b0};
  int ex [2][4];
  int ew [2];
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        run[i] <= 1'b0; e[i] <= 0; mdone[i] <= 1'b0; mvalid[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (run[i]) begin
          e[i]     <= e[i] + 1;
          mdone[i] <= (e[i] + 1 == ncell(i) + lat(i) + 2);
          if (e[i] + 1 == ncell(i) + lat(i) + 2) begin
            run[i]    <= 1'b0;
            mvalid[i] <= 1'b1;
          end
        end else begin
          mdone[i] <= 1'b0;
          if (start[i] && !mdone[i]) begin
            run[i]    <= 1'b1;
            e[i]      <= 0;
            mvalid[i] <= 1'b0;
            for (int p = 0; p < 4; p++) ex[i][p] <= ecl[i][p];
            ew[i] <= ewl[i];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("busy", i, busy[i], run[i]);
      chk("done", i, done[i], mdone[i]);
      chk("valid", i, valid[i], mvalid[i]);
      if (run[i]) begin
        int k;
        k = (e[i] < ncell(i)) ? e[i] : ncell(i) - 1;
        chk("addr", i, addr[i], ca(k / ht(i), k % ht(i)));
      end else begin
        chk("p1", i, c1[i], mvalid[i] ? ex[i][0] : 0);
        chk("p2", i, c2[i], mvalid[i] ? ex[i][1] : 0);
        chk("p3", i, c3[i], mvalid[i] ? ex[i][2] : 0);
        chk("p4", i, c4[i], mvalid[i] ? ex[i][3] : 0);
        chk("winner", i, win[i], mvalid[i] ? ew[i] : 0);
      end
    end
  end

  int dcount [2] = '{0, 0};
  always @(negedge clk) for (int i = 0; i < 2; i++) if (done[i]) dcount[i]++;

  int t0 [2];

  task automatic pulse(input int i);
    repeat (2) @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    t0[i] = cyc;
  endtask

  // Returns in the done cycle (just after the edge that raised done).
  task automatic wait_done(input int i, output int latency);
    int n;
    n = 0;
    latency = -1;
    while (n < 25000) begin
      @(posedge clk);
      #1;
      n++;
      if (done[i]) begin
        latency = cyc - t0[i];
        break;
      end
    end
    if (latency < 0) chk("done_timeout", i, 0, 1);
  endtask

  task automatic fill_big(input int n1, input int n2, input int n3, input int n4);
    int c;
    for (int k = 0; k < 19200; k++)
      mem[0][15'(ca(k / 120, k % 120))] = (k % 3 == 0) ? 3'b111 : 3'b000;
    for (int idx = 0; idx < n1 + n2 + n3 + n4; idx++) begin
      c = (idx * 7919) % 19200;
      mem[0][15'(ca(c / 120, c % 120))] =
        (idx < n1) ? 3'b001 : (idx < n1 + n2) ? 3'b010 :
        (idx < n1 + n2 + n3) ? 3'b100 : 3'b110;
    end
    tally(0);
  endtask

  task automatic lit_counts(input string nm, input int i, input int a, input int b,
                            input int c, input int d, input int w);
    chk({nm, "_p1"}, i, c1[i], a);
    chk({nm, "_p2"}, i, c2[i], b);
    chk({nm, "_p3"}, i, c3[i], c);
    chk({nm, "_p4"}, i, c4[i], d);
    chk({nm, "_win"}, i, win[i], w);
    chk({nm, "_valid"}, i, valid[i], 1);
  endtask

  initial begin
    int l, d0;
    rst = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    for (int i = 0; i < 2; i++) for (int a = 0; a < 32768; a++) mem[i][a] = 3'b000;
    tally(0);
    tally(1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_addr", i, addr[i], 0);
      chk("rst_busy", i, busy[i], 0);
      chk("rst_valid", i, valid[i], 0);
    end
    rst = 1'b0;

    // Empty 3x2 field, latency 3: 6+3+2 edges to done.
    pulse(1);
    wait_done(1, l);
    chk("empty_latency", 1, l, 11);
    lit_counts("empty", 1, 0, 0, 0, 0, 0);

    // Tie p2=p3 on the small field; the first q cycles carry junk 001.
    mem[1][15'(ca(0, 0))] = 3'b010;
    mem[1][15'(ca(0, 1))] = 3'b100;
    mem[1][15'(ca(1, 0))] = 3'b001;
    mem[1][15'(ca(1, 1))] = 3'b111;
    mem[1][15'(ca(2, 0))] = 3'b010;
    mem[1][15'(ca(2, 1))] = 3'b100;
    tally(1);
    pulse(1);
    wait_done(1, l);
    chk("tie_latency", 1, l, 11);
    lit_counts("tie", 1, 1, 2, 2, 0, 1);

    // Start coincident with done is dropped; the next one restarts.
    start[1] = 1'b1;
    @(posedge clk);
    #1;
    start[1] = 1'b0;
    chk("coinc_ignored_busy", 1, busy[1], 0);
    pulse(1);
    chk("restart_valid_drop", 1, valid[1], 0);
    wait_done(1, l);
    lit_counts("restart", 1, 1, 2, 2, 0, 1);

    // Mixed colours on the full field, with stray starts during the sweep.
    fill_big(100, 250, 7, 3000);
    d0 = dcount[0];
    pulse(0);
    repeat (100) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (9000) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, l);
    chk("mixed_latency", 0, l, 19203);
    lit_counts("mixed", 0, 100, 250, 7, 3000, 3);
    repeat (3) @(negedge clk);
    chk("single_done", 0, dcount[0] - d0, 1);

    // Two-way tie on the full field.
    fill_big(10, 50, 50, 10);
    pulse(0);
    wait_done(0, l);
    lit_counts("bigtie", 0, 10, 50, 50, 10, 1);

    // Reset 500 cycles into a sweep, then a fresh tally of new contents.
    fill_big(5, 0, 9, 5);
    pulse(0);
    repeat (500) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_addr", 0, addr[0], 0);
    chk("midrst_busy", 0, busy[0], 0);
    chk("midrst_valid", 0, valid[0], 0);
    chk("midrst_done", 0, done[0], 0);
    chk("midrst_p1", 0, c1[0], 0);
    chk("midrst_p4", 0, c4[0], 0);
    @(negedge clk);
    rst = 1'b0;
    fill_big(20, 3, 3, 1);
    pulse(0);
    wait_done(0, l);
    chk("postrst_latency", 0, l, 19203);
    lit_counts("postrst", 0, 20, 3, 3, 1, 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
